// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tc_timer
//  Brief    : Memory-mapped down-counting timer with one-shot and
//             auto-reload modes and a maskable interrupt. Register window
//             of 16 bytes at BASE_ADDR: CTRL (0x0), PRESET (0x4),
//             COUNT (0x8, read-only), reserved (0xC).
//  Config   : define TC_TIMER_BYTE_WRITE_EN to enable per-byte writes to
//             CTRL and PRESET; otherwise only full-word writes take effect.
//  Revision : 1.0 - initial release
// ============================================================================
module tc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] C_REG_CTRL   = 2'b00;
    localparam logic [1:0] C_REG_PRESET = 2'b01;
    localparam logic [1:0] C_REG_COUNT  = 2'b10;
    localparam logic [1:0] C_MODE_AUTO  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CNT  = 2'b10,
        S_INT  = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ctrl;      // [3] IM, [2:1] MODE, [0] EN
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irqf;

    logic        w_sel;
    logic        w_wr;
    logic [31:0] w_bmask;
    logic        w_ctrl_wr;
    logic        w_ctrl_b0;
    logic        w_preset_wr;
    logic        w_force_idle;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_irqf_set;
    logic        w_irqf_clr;
    logic        w_en_clr;
    logic        w_unused_addr;

    // Word offset only; byte offset within a word has no meaning here.
    assign w_unused_addr = ^addr[1:0];

    assign w_sel = (addr[31:4] == BASE_ADDR[31:4]);

`ifdef TC_TIMER_BYTE_WRITE_EN
    assign w_wr    = w_sel && (byteen != 4'b0000);
    assign w_bmask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
`else
    assign w_wr    = w_sel && (byteen == 4'b1111);
    assign w_bmask = {32{1'b1}};
`endif

    assign w_ctrl_wr   = w_wr && (addr[3:2] == C_REG_CTRL);
    // All CTRL fields live in byte 0, so only that lane can change them.
    assign w_ctrl_b0   = w_ctrl_wr && w_bmask[0];
    assign w_preset_wr = w_wr && (addr[3:2] == C_REG_PRESET);
    // Software clearing EN stops the timer immediately, whatever the state.
    assign w_force_idle = w_ctrl_b0 && !wdata[0];

    // Next-state and datapath control; writes that stop the timer suppress
    // any counter or flag action of the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_irqf_set  = 1'b0;
        w_irqf_clr  = 1'b0;
        w_en_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cnt_load  = 1'b1;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == 32'd0) begin
                    w_irqf_set  = 1'b1;
                    w_state_nxt = S_INT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_INT: begin
                if (r_ctrl[2:1] == C_MODE_AUTO) begin
                    w_irqf_clr  = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_force_idle) begin
            w_state_nxt = S_IDLE;
            w_cnt_load  = 1'b0;
            w_cnt_dec   = 1'b0;
            w_irqf_set  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CTRL register: a CPU write wins over the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 4'b0000;
        end else if (w_ctrl_b0) begin
            r_ctrl <= wdata[3:0];
        end else if (w_en_clr) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    // PRESET register; only sampled into COUNT on LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= 32'd0;
        end else if (w_preset_wr) begin
            r_preset <= (r_preset & ~w_bmask) | (wdata & w_bmask);
        end
    end

    // COUNT register: load from PRESET, then count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 32'd0;
        end else if (w_cnt_load) begin
            r_count <= r_preset;
        end else if (w_cnt_dec) begin
            r_count <= r_count - 32'd1;
        end
    end

    // Interrupt flag: any CTRL write acknowledges it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irqf <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_irqf <= 1'b0;
        end else if (w_irqf_set) begin
            r_irqf <= 1'b1;
        end else if (w_irqf_clr) begin
            r_irqf <= 1'b0;
        end
    end

    // Combinational read mux.
    always_comb begin
        rdata = 32'd0;
        if (w_sel) begin
            case (addr[3:2])
                C_REG_CTRL:   rdata = {28'd0, r_ctrl};
                C_REG_PRESET: rdata = r_preset;
                C_REG_COUNT:  rdata = r_count;
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign irq = r_irqf & r_ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tc_timer
//  Brief    : Self-checking bench for tc_timer: directed scenarios plus
//             randomized bus traffic against a timeline reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tc_timer;

    localparam logic [31:0] C_BASE = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    tc_timer #(.BASE_ADDR(C_BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. The timer run is a position on a timeline:
    //   pos = -1          stopped
    //   pos =  0          reload cycle (PRESET latched as n)
    //   pos =  1 .. n+1   counting, COUNT = n - (pos-1)
    //   pos =  n+2        terminal cycle, flag raised on arrival
    // ------------------------------------------------------------------
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_irqf;
    longint      m_pos;
    longint      m_n;

    task automatic m_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_irqf   = 1'b0;
        m_pos    = -1;
        m_n      = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != C_BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_wr_ok(input logic [3:0] be);
`ifdef TC_TIMER_BYTE_WRITE_EN
        return be != 4'd0;
`else
        return be == 4'hF;
`endif
    endfunction

    function automatic logic [31:0] m_mask(input logic [3:0] be);
`ifdef TC_TIMER_BYTE_WRITE_EN
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    // Advance the model by one clock edge using the current bus inputs.
    task automatic m_step();
        logic [3:0]  c0;
        logic [31:0] p0;
        logic [31:0] mk;
        longint      pos0;
        logic        wr;
        logic        cw;
        logic        en_wr;
        logic        stop;
        c0    = m_ctrl;
        p0    = m_preset;
        pos0  = m_pos;
        mk    = m_mask(byteen);
        wr    = (addr[31:4] == C_BASE[31:4]) && m_wr_ok(byteen);
        cw    = wr && (addr[3:2] == 2'd0);
        en_wr = cw && mk[0];
        stop  = en_wr && !wdata[0];
        if (en_wr) m_ctrl = wdata[3:0];
        if (wr && addr[3:2] == 2'd1) m_preset = (m_preset & ~mk) | (wdata & mk);
        if (stop) begin
            m_pos = -1;
        end else if (pos0 == -1) begin
            if (c0[0]) m_pos = 0;
        end else if (pos0 == 0) begin
            m_n     = longint'(p0);
            m_count = p0;
            m_pos   = 1;
        end else if (pos0 <= m_n + 1) begin
            if (pos0 == m_n + 1) begin
                m_pos  = m_n + 2;
                m_irqf = 1'b1;
            end else begin
                m_count = 32'(m_n - pos0);
                m_pos   = pos0 + 1;
            end
        end else begin
            if (c0[2:1] == 2'b01) begin
                m_irqf = 1'b0;
                m_pos  = 0;
            end else begin
                if (!en_wr) m_ctrl[0] = 1'b0;
                m_pos = -1;
            end
        end
        if (cw) m_irqf = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // Called just after an edge: sample outputs, take one edge, update model.
    task automatic tick(input string tag);
        #2;
        check({tag, " rdata"}, rdata, m_read(addr));
        check({tag, " irq"}, {31'd0, irq}, {31'd0, m_ctrl[3] & m_irqf});
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input string tag);
        addr   = a;
        byteen = be;
        wdata  = d;
        tick(tag);
        byteen = 4'd0;
    endtask

    task automatic apply_reset();
        byteen = 4'd0;
        reset  = 1'b0;
        #1;
        m_reset();
        addr = C_BASE + 32'h8;
        #1;
        check("reset count", rdata, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        addr = C_BASE;
        #1;
        check("reset ctrl", rdata, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        m_step();
        #1;
    endtask

    // Idle cycles until the model shows COUNT==target while counting.
    task automatic wait_count(input logic [31:0] target, input string tag);
        logic found;
        found = 1'b0;
        addr  = C_BASE + 32'h8;
        for (int k = 0; k < 60; k++) begin
            if (m_count == target && m_pos >= 1) begin
                found = 1'b1;
                break;
            end
            tick(tag);
        end
        check({tag, " reached"}, {31'd0, found}, 32'd1);
    endtask

    // ------------------------------------------------------------------
    initial begin
        int          pulses;
        int          highs;
        logic [31:0] rv;
        logic [31:0] d;
        logic [3:0]  be;

        reset  = 1'b0;
        addr   = 32'd0;
        byteen = 4'd0;
        wdata  = 32'd0;
        m_reset();
        apply_reset();

        // One-shot: PRESET=5, CTRL=IM|EN, irq after the 8th edge.
        bus(C_BASE + 32'h4, 4'hF, 32'd5, "oneshot preset");
        bus(C_BASE, 4'hF, 32'h9, "oneshot ctrl");
        addr = C_BASE + 32'h8;
        for (int k = 0; k < 7; k++) tick("oneshot run");
        #1;
        check("oneshot irq before edge 8", {31'd0, irq}, 32'd0);
        tick("oneshot run");
        #1;
        check("oneshot irq after edge 8", {31'd0, irq}, 32'd1);
        for (int k = 0; k < 4; k++) tick("oneshot hold");
        addr = C_BASE;
        #1;
        check("oneshot EN cleared", rdata, 32'h8);
        check("oneshot irq held", {31'd0, irq}, 32'd1);
        bus(C_BASE, 4'hF, 32'h8, "oneshot ack");
        #1;
        check("oneshot irq dropped", {31'd0, irq}, 32'd0);

        // Auto-reload: PRESET=2, CTRL=IM|MODE01|EN -> pulse every 5 cycles.
        apply_reset();
        bus(C_BASE + 32'h4, 4'hF, 32'd2, "auto preset");
        bus(C_BASE, 4'hF, 32'hB, "auto ctrl");
        pulses = 0;
        addr = C_BASE + 32'h8;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (irq) pulses++;
            tick("auto run");
        end
        check("auto pulse count", pulses, 32'd3);
        bus(C_BASE, 4'hF, 32'h0, "auto stop");

        // Stop by CTRL write during counting: COUNT frozen at 3.
        bus(C_BASE + 32'h4, 4'hF, 32'd10, "stop preset");
        bus(C_BASE, 4'hF, 32'h9, "stop ctrl");
        wait_count(32'd3, "stop wait");
        bus(C_BASE, 4'hF, 32'h0, "stop write");
        addr = C_BASE + 32'h8;
        for (int k = 0; k < 4; k++) tick("stop idle");
        #1;
        check("stop count frozen", rdata, 32'd3);
        check("stop no irq", {31'd0, irq}, 32'd0);

        // Writes to COUNT, reserved and outside the window change nothing.
        bus(C_BASE + 32'h4, 4'hF, 32'd4, "ign preset");
        bus(C_BASE + 32'h8, 4'hF, 32'hDEAD_BEEF, "ign count");
        bus(C_BASE + 32'hC, 4'hF, 32'h1234_5678, "ign rsvd");
        bus(C_BASE + 32'h10, 4'hF, 32'h0000_000F, "ign outside");
        bus(C_BASE - 32'h10, 4'hF, 32'h0000_0009, "ign outside lo");
        addr = C_BASE + 32'h10;
        #1;
        check("outside rdata", rdata, 32'd0);
        addr = C_BASE + 32'h4;
        #1;
        check("ign preset kept", rdata, 32'd4);
        addr = C_BASE + 32'h8;
        #1;
        check("ign count kept", rdata, 32'd3);

        // Partial write of PRESET.
        apply_reset();
        bus(C_BASE + 32'h4, 4'b0001, 32'hFFFF_FFFF, "partial preset");
        addr = C_BASE + 32'h4;
        #1;
`ifdef TC_TIMER_BYTE_WRITE_EN
        check("partial preset", rdata, 32'h0000_00FF);
`else
        check("partial preset", rdata, 32'h0000_0000);
`endif

        // Reset mid-count at COUNT=7, then no irq after release.
        bus(C_BASE + 32'h4, 4'hF, 32'd10, "rst preset");
        bus(C_BASE, 4'hF, 32'h9, "rst ctrl");
        wait_count(32'd7, "rst wait");
        apply_reset();
        highs = 0;
        addr = C_BASE + 32'h8;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (irq) highs++;
            tick("rst after");
        end
        check("no irq after reset", highs, 32'd0);

        // Randomized bus traffic.
        for (int i = 0; i < 3000; i++) begin
            rv     = $urandom_range(0, 999);
            d      = $urandom;
            be     = 4'hF;
            if ($urandom_range(0, 3) == 0) be = 4'($urandom_range(0, 15));
            addr   = C_BASE | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            byteen = 4'd0;
            wdata  = d;
            if (rv < 40) begin
                addr[3:2] = 2'd0;
                wdata     = {d[31:4], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             1'($urandom_range(0, 3) != 0)};
                byteen    = be;
            end else if (rv < 80) begin
                addr[3:2] = 2'd1;
                wdata     = 32'($urandom_range(0, 6));
                byteen    = be;
            end else if (rv < 110) begin
                addr[3]   = 1'b1;
                byteen    = be;
            end else if (rv < 140) begin
                addr = d;
                if (addr[31:4] == C_BASE[31:4]) addr[31] = ~addr[31];
                wdata  = 32'h0000_0009;
                byteen = 4'hF;
            end else if (rv < 143) begin
                apply_reset();
                continue;
            end
            tick("rand");
            byteen = 4'd0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tc_timer.md
TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, meaning the word-aligned base of the 16-byte register window.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  32  meaning the CPU data address (the m_data_addr equivalent).
REQ-005 SHALL have port byteen  input  4  meaning the CPU byte write enables; any bit set means a write.
REQ-006 SHALL have port wdata  input  32  meaning the CPU write data.
REQ-007 SHALL have port rdata  output  32  meaning the read data of the selected register.
REQ-008 SHALL have port irq  output  1  meaning the interrupt request.

Function
REQ-009 SHALL select the block when addr[31:4]==BASE_ADDR[31:4]; addr[3:2] SHALL pick CTRL=00, PRESET=01, COUNT=10, reserved=11; addr[1:0] SHALL be ignored.
REQ-010 SHALL define CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (irq mask); bits [31:4] SHALL read 0.
REQ-011 SHALL make COUNT read-only; writes to COUNT or to reserved SHALL be ignored.
REQ-012 SHALL drive rdata combinationally as the selected register, and as 0 when not selected or reserved.
REQ-013 SHALL implement states IDLE, LOAD, CNT, INT, advancing once per clk edge.
REQ-014 SHALL, in IDLE, go to LOAD when EN=1, else stay.
REQ-015 SHALL, in LOAD, copy PRESET into COUNT and go to CNT.
REQ-016 SHALL, in CNT, go to IDLE if EN=0; else go to INT if COUNT==0; else decrement COUNT by 1 (32-bit, no wrap below 0).
REQ-017 SHALL, on entering INT, set the internal flag IRQF.
REQ-018 SHALL, in INT with MODE=00, clear EN and go to IDLE, with IRQF held.
REQ-019 SHALL, in INT with MODE=01, clear IRQF on the next edge (one-cycle pulse) and go to LOAD.
REQ-020 SHALL drive irq = IRQF & IM.
REQ-021 SHALL clear IRQF on any CTRL write.
REQ-022 SHALL make a CPU CTRL write take priority over FSM updates of EN in the same cycle.
REQ-023 SHALL force the next state to IDLE when a CTRL write clears EN in any state.
REQ-024 SHALL apply a PRESET write during CNT only at the next LOAD, without changing COUNT.
REQ-025 SHALL produce the first irq N+3 edges after the edge that writes EN=1, with PRESET=N, MODE=00, IM=1; for auto-reload, the period SHALL be N+3 cycles.

Reset
REQ-026 SHALL, while reset is low, asynchronously force CTRL, PRESET, COUNT and IRQF to 0 and the state to IDLE, so that irq=0.
REQ-027 SHALL abandon any count in progress when reset asserts mid-operation; no irq SHALL be produced after release until EN is rewritten.

Configuration
REQ-028 SHALL honour the macro TC_TIMER_BYTE_WRITE_EN: when defined, CTRL and PRESET writes SHALL update only the bytes whose byteen bit is set.
REQ-029 SHALL, without TC_TIMER_BYTE_WRITE_EN, perform a register write only when byteen==4'b1111; partial writes SHALL be ignored, including the IRQF clear.

Verification
REQ-030 SHALL cover: reset low mid-count with COUNT=7 -> COUNT=0, state IDLE, irq=0 immediately, and irq stays 0 after release.
REQ-031 SHALL cover: PRESET=5, CTRL=4'b1001 -> irq rises after edge 8; irq stays high and EN reads 0 until a CTRL write, which drops irq.
REQ-032 SHALL cover: PRESET=2, CTRL=4'b1011 -> a one-cycle irq pulse every 5 cycles; COUNT cycles 2,1,0.
REQ-033 SHALL cover: a CTRL write of 0 during CNT with COUNT=3 -> IDLE next edge, COUNT frozen at its value, no irq.
REQ-034 SHALL cover: a write to COUNT or reserved, or to an address outside the window -> no state change, and rdata=0 outside the window.
REQ-035 SHALL cover: byteen=4'b0001 with wdata=32'hFFFF_FFFF to PRESET (initial 0) -> PRESET=32'h0000_00FF with the macro, and 0 without it.
